// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: register-hazard interlock, multiply/divide busy tracking, stall counter.
// Define PIPE_STALL_MD_EN to build the multiply/divide busy tracker; without it MD_busy is tied low.
//
// md_cnt state | meaning
// IDLE (0)     | multiply/divide unit free
// BUSY (!=0)   | unit occupied, md_cnt cycles remain
module pipe_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_md,
  input  logic        E_start_mult,
  input  logic        E_start_div,
  output logic        F_PC_WE,
  output logic        D_Reg_WE,
  output logic        E_Reg_clr,
  output logic        MD_busy,
  output logic [31:0] stall_cnt
);

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  // A stage only blocks D when its result arrives later than D needs it.
  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               (((E_A3 == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                ((M_A3 == D_rs) && (M_Tnew > D_Tuse_rs)));
    stall_rt = (D_rt != 5'd0) &&
               (((E_A3 == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                ((M_A3 == D_rt) && (M_Tnew > D_Tuse_rt)));
  end

`ifdef PIPE_STALL_MD_EN
  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  logic [3:0] md_cnt;
  logic [3:0] md_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) md_cnt <= 4'd0;
    else     md_cnt <= md_cnt_nxt;
  end

  // Divide wins a simultaneous start; a start while busy reloads.
  always_comb begin
    md_cnt_nxt = md_cnt;
    if (E_start_div)         md_cnt_nxt = DIV_LD;
    else if (E_start_mult)   md_cnt_nxt = MULT_LD;
    else if (md_cnt != 4'd0) md_cnt_nxt = md_cnt - 4'd1;
  end

  always_comb begin
    MD_busy  = (md_cnt != 4'd0);
    stall_md = D_is_md && (MD_busy || E_start_mult || E_start_div);
  end
`else
  logic unused_md;
  assign unused_md = ^{D_is_md, E_start_mult, E_start_div};
  assign MD_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

  always_comb begin
    stall     = stall_rs || stall_rt || stall_md;
    F_PC_WE   = ~stall;
    D_Reg_WE  = ~stall;
    E_Reg_clr = stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl; expectations adapt to PIPE_STALL_MD_EN.
module tb_pipe_stall_ctrl;

`ifdef PIPE_STALL_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_is_md, E_start_mult, E_start_div;
  logic        F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy;
  logic [31:0] stall_cnt;

  pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst(rst),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .D_is_md(D_is_md), .E_start_mult(E_start_mult), .E_start_div(E_start_div),
    .F_PC_WE(F_PC_WE), .D_Reg_WE(D_Reg_WE), .E_Reg_clr(E_Reg_clr),
    .MD_busy(MD_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    logic        pc_we;
    logic        reg_we;
    logic        clr;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [4:0] rs, rt, ea3, ma3;
    logic [1:0] tuse_rs, tuse_rt, etnew, mtnew;
    logic       stall;
  } hvec_t;

  exp_t        sbq[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic clear_inputs();
    D_rs = 5'd0; D_rt = 5'd0; E_A3 = 5'd0; M_A3 = 5'd0;
    D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
    D_is_md = 1'b0; E_start_mult = 1'b0; E_start_div = 1'b0;
  endtask

  // Queue the expected outputs for the cycle being driven; stall_cnt advances at the next edge.
  task automatic push_exp(input string name, input int cyc, input logic stl, input logic busy);
    sbq.push_back('{name, cyc, ~stl, ~stl, stl, busy, exp_cnt});
    if (stl) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    push_exp("reset_asserted", 0, 1'b0, 1'b0);
    #1;
    e = sbq.pop_front(); checks++;
    if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
      errors++;
      $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
               e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    push_exp("reset_released", 1, 1'b0, 1'b0);
    #1;
    e = sbq.pop_front(); checks++;
    if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
      errors++;
      $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
               e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
    end
  endtask

  task automatic test_hazards();
    hvec_t tbl[9];
    //        rs    rt    ea3   ma3   tuse_rs tuse_rt etnew mtnew stall
    tbl[0] = '{5'd5, 5'd0, 5'd5, 5'd0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b1};
    tbl[1] = '{5'd0, 5'd7, 5'd0, 5'd7, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1};
    tbl[2] = '{5'd3, 5'd0, 5'd3, 5'd0, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0};
    tbl[3] = '{5'd3, 5'd0, 5'd3, 5'd0, 2'd1, 2'd0, 2'd2, 2'd0, 1'b1};
    tbl[4] = '{5'd4, 5'd0, 5'd5, 5'd0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0};
    tbl[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0};
    tbl[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0};
    tbl[7] = '{5'd9, 5'd0, 5'd0, 5'd9, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
    tbl[8] = '{5'd6, 5'd0, 5'd6, 5'd6, 2'd1, 2'd0, 2'd0, 2'd2, 1'b1};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clear_inputs();
      D_rs = tbl[i].rs; D_rt = tbl[i].rt; E_A3 = tbl[i].ea3; M_A3 = tbl[i].ma3;
      D_Tuse_rs = tbl[i].tuse_rs; D_Tuse_rt = tbl[i].tuse_rt;
      E_Tnew = tbl[i].etnew; M_Tnew = tbl[i].mtnew;
      push_exp("hazard_table", i, tbl[i].stall, 1'b0);
      #1;
      e = sbq.pop_front(); checks++;
      if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
                 e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
      end
    end
  endtask

  task automatic test_load_use_held();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clear_inputs();
      D_rs = 5'd5; D_Tuse_rs = 2'd0; E_A3 = 5'd5; E_Tnew = 2'd2;
      push_exp("load_use_held", k, 1'b1, 1'b0);
      #1;
      e = sbq.pop_front(); checks++;
      if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
                 e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
      end
    end
  endtask

  // Start cycle plus five busy cycles stall; released on the seventh.
  task automatic test_multiply();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clear_inputs();
      E_start_mult = (k == 0);
      D_is_md = 1'b1;
      push_exp("multiply", k, MD_EN && (k <= 5), MD_EN && (k >= 1) && (k <= 5));
      #1;
      e = sbq.pop_front(); checks++;
      if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
                 e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
      end
    end
  endtask

  task automatic test_simultaneous_starts();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      clear_inputs();
      E_start_mult = (k == 0);
      E_start_div  = (k == 0);
      D_is_md      = (k == 0);
      push_exp("simul_starts", k, MD_EN && (k == 0), MD_EN && (k >= 1) && (k <= 10));
      #1;
      e = sbq.pop_front(); checks++;
      if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
                 e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
      end
    end
  endtask

  // Multiply then a divide issued while busy reloads the full divide latency.
  task automatic test_back_to_back();
    logic busy, start, dmd;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      clear_inputs();
      E_start_mult = (k == 0);
      E_start_div  = (k == 3);
      dmd   = (k >= 12);
      D_is_md = dmd;
      busy  = MD_EN && (k >= 1) && (k <= 13);
      start = (k == 0) || (k == 3);
      push_exp("back_to_back", k, MD_EN && dmd && (busy || start), busy);
      #1;
      e = sbq.pop_front(); checks++;
      if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
                 e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      clear_inputs();
      E_start_div = (k == 0);
      D_is_md = 1'b1;
      push_exp("pre_reset_div", k, MD_EN, MD_EN && (k >= 1));
      #1;
      e = sbq.pop_front(); checks++;
      if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
                 e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
      end
    end
    // md_cnt is 6 here; reset lands between edges.
    rst = 1'b1;
    exp_cnt = 32'd0;
    push_exp("reset_mid_div", 0, 1'b0, 1'b0);
    #1;
    e = sbq.pop_front(); checks++;
    if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
      errors++;
      $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
               e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
    end
    #1;
    rst = 1'b0;
    D_is_md = 1'b0;
    E_start_mult = 1'b1;
    @(negedge clk);
    clear_inputs();
    push_exp("first_edge_after_reset", 1, 1'b0, MD_EN);
    #1;
    e = sbq.pop_front(); checks++;
    if ({F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt} !== {e.pc_we, e.reg_we, e.clr, e.busy, e.cnt}) begin
      errors++;
      $display("FAIL %s cyc=%0d: got pc_we=%b reg_we=%b clr=%b busy=%b cnt=%0d, want %b %b %b %b %0d",
               e.name, e.cyc, F_PC_WE, D_Reg_WE, E_Reg_clr, MD_busy, stall_cnt, e.pc_we, e.reg_we, e.clr, e.busy, e.cnt);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_hazards();
    test_load_use_held();
    test_multiply();
    test_simultaneous_starts();
    test_back_to_back();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles after a multiply start.
REQ-002 Parameter DIV_CYC, default 10: busy cycles after a divide start.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 D_rs, D_rt  input  5 each  source register numbers of the instruction in D.
REQ-006 D_Tuse_rs, D_Tuse_rt  input  2 each  cycles until D needs rs/rt.
REQ-007 E_A3, M_A3  input  5 each  destination register numbers in E and M; 0 means no write.
REQ-008 E_Tnew, M_Tnew  input  2 each  cycles until the E/M result is available.
REQ-009 D_is_md  input  1  D instruction uses the multiply/divide unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 E_start_mult, E_start_div  input  1 each  multiply/divide issuing from E this cycle.
REQ-011 F_PC_WE  output  1  PC write enable.
REQ-012 D_Reg_WE  output  1  F->D pipeline register write enable.
REQ-013 E_Reg_clr  output  1  synchronous bubble insert into the D->E register.
REQ-014 MD_busy  output  1  multiply/divide unit is occupied.
REQ-015 stall_cnt  output  32  number of stall cycles since reset.

Function
REQ-016 stall_rs SHALL be 1 iff D_rs!=0 and ((E_A3==D_rs and E_Tnew>D_Tuse_rs) or (M_A3==D_rs and M_Tnew>D_Tuse_rs)); stall_rt SHALL be defined identically with rt.
REQ-017 Register 0 SHALL never cause a stall, regardless of E_A3/M_A3 matching.
REQ-018 A 4-bit down-counter md_cnt SHALL implement two states: IDLE (md_cnt==0) and BUSY (md_cnt!=0).
REQ-019 IDLE->BUSY: on posedge with E_start_div=1, md_cnt SHALL load DIV_CYC; otherwise, with E_start_mult=1, md_cnt SHALL load MULT_CYC.
REQ-020 When both starts are asserted together, divide SHALL win and DIV_CYC SHALL load.
REQ-021 In BUSY without a start, md_cnt SHALL decrement by 1 each cycle; BUSY->IDLE SHALL occur when it reaches 0.
REQ-022 A start during BUSY SHALL reload md_cnt per REQ-019/020.
REQ-023 md_cnt SHALL never wrap below 0.
REQ-024 MD_busy SHALL equal (md_cnt!=0), driven combinationally from the registered state.
REQ-025 stall_md SHALL be D_is_md and (MD_busy or E_start_mult or E_start_div).
REQ-026 stall SHALL be stall_rs or stall_rt or stall_md.
REQ-027 Combinational outputs: F_PC_WE = D_Reg_WE = ~stall; E_Reg_clr = stall.
REQ-028 Latency: zero cycles from inputs to stall outputs; one cycle from a start to MD_busy.
REQ-029 stall_cnt SHALL increment by 1 on each posedge where stall=1 and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 rst=1 SHALL asynchronously clear md_cnt to 0 and stall_cnt to 0, including mid-operation.
REQ-031 With rst=1 and all inputs 0: F_PC_WE=1, D_Reg_WE=1, E_Reg_clr=0, MD_busy=0.
REQ-032 On the first posedge after rst deasserts, md_cnt SHALL act on the inputs as normal.

Configuration
REQ-033 Macro PIPE_STALL_MD_EN defined: REQ-018 to REQ-025 SHALL be included as specified.
REQ-034 Macro PIPE_STALL_MD_EN undefined: no md_cnt logic, MD_busy tied to 0, stall_md=0, D_is_md/E_start_* ignored; hazard stalls and stall_cnt unchanged.

Verification
REQ-035 Load-use: D_rs=5, D_Tuse_rs=0, E_A3=5, E_Tnew=2 -> F_PC_WE=0, D_Reg_WE=0, E_Reg_clr=1; stall_cnt +1 per cycle held.
REQ-036 Zero register: D_rs=0, E_A3=0, E_Tnew=2, D_Tuse_rs=0 -> no stall, F_PC_WE=1.
REQ-037 Multiply: E_start_mult pulse, then D_is_md=1 -> stall in the start cycle plus 5 busy cycles; MD_busy high exactly 5 cycles; released on the 7th cycle.
REQ-038 Simultaneous starts: E_start_mult=E_start_div=1 for one cycle -> MD_busy high for 10 cycles.
REQ-039 Reset mid-divide: rst asserted at md_cnt=6 between clock edges -> MD_busy=0 immediately, stall_cnt=0, no stall with D_is_md=1.
REQ-040 Macro undefined: E_start_div=1 with D_is_md=1 -> MD_busy=0 and no stall.
